// File: rtl/instr_encode_rv.sv
// instr_encode_rv -- streaming RV32I instruction encoder.
//
// Takes decoded instruction fields over a valid/ready handshake, packs them
// into 32-bit RV32I words, tags each word with a running instruction-memory
// address and holds the results in a 2-entry output FIFO.
//
// Optional build macro: ICE_RISC_ENC_RANGE_CHECK_EN
//   defined   -> immediates that do not fit their format make a request illegal
//   undefined -> out-of-range immediate bits are silently truncated
//
// Ports:
//   iwClk, iwnRst        clock (rising edge), asynchronous active-low reset
//   iwValid / owInReady  request handshake (owInReady depends on registers only)
//   iwKind               0=LUI 1=AUIPC 2=JAL 3=JALR 4=BRANCH 5=LOAD 6=STORE
//                        7=OP_IMM 8=OP, 9..15 illegal
//   iwFunct3, iwAlt      funct3 and funct7=0100000 select
//   iwRd, iwRs1, iwRs2   register numbers
//   iwImm                immediate (byte offset for B/J, full value for U)
//   iwAddrLoad, iwAddr   load the address counter
//   owValid / iwOutReady FIFO head handshake
//   owInstr, owAddr      encoded word at FIFO head and its address
//   orIllegalPulse       one-cycle pulse after an illegal request is dropped
//   orIllegalCount       saturating count of dropped requests
module instr_encode_rv #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwValid,
  output logic        owInReady,
  input  logic [3:0]  iwKind,
  input  logic [2:0]  iwFunct3,
  input  logic        iwAlt,
  input  logic [4:0]  iwRd,
  input  logic [4:0]  iwRs1,
  input  logic [4:0]  iwRs2,
  input  logic [31:0] iwImm,
  input  logic        iwAddrLoad,
  input  logic [31:0] iwAddr,
  output logic        owValid,
  input  logic        iwOutReady,
  output logic [31:0] owInstr,
  output logic [31:0] owAddr,
  output logic        orIllegalPulse,
  output logic [7:0]  orIllegalCount
);

  localparam logic [3:0] K_LUI    = 4'd0;
  localparam logic [3:0] K_AUIPC  = 4'd1;
  localparam logic [3:0] K_JAL    = 4'd2;
  localparam logic [3:0] K_JALR   = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4;
  localparam logic [3:0] K_LOAD   = 4'd5;
  localparam logic [3:0] K_STORE  = 4'd6;
  localparam logic [3:0] K_OP_IMM = 4'd7;
  localparam logic [3:0] K_OP     = 4'd8;

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  typedef enum logic [2:0] {FMT_U, FMT_J, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_R} fmt_e;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic        is_shift;
  logic        kind_ok;
  logic        alt_ok;
  logic        range_ok;
  logic        legal;
  logic [31:0] enc_word;

  // ---------------- field decode / packing ----------------
  always_comb begin
    fmt      = FMT_R;
    opcode   = 7'b0000000;
    kind_ok  = 1'b1;
    funct7   = iwAlt ? 7'b0100000 : 7'b0000000;
    is_shift = (iwFunct3 == 3'b001) || (iwFunct3 == 3'b101);
    case (iwKind)
      K_LUI:    begin fmt = FMT_U; opcode = 7'b0110111; end
      K_AUIPC:  begin fmt = FMT_U; opcode = 7'b0010111; end
      K_JAL:    begin fmt = FMT_J; opcode = 7'b1101111; end
      K_JALR:   begin fmt = FMT_I; opcode = 7'b1100111; kind_ok = (iwFunct3 == 3'b000); end
      K_BRANCH: begin
        fmt = FMT_B; opcode = 7'b1100011;
        kind_ok = (iwFunct3 != 3'b010) && (iwFunct3 != 3'b011);
      end
      K_LOAD:   begin
        fmt = FMT_I; opcode = 7'b0000011;
        kind_ok = (iwFunct3 != 3'b011) && (iwFunct3[2:1] != 2'b11);
      end
      K_STORE:  begin fmt = FMT_S; opcode = 7'b0100011; kind_ok = (iwFunct3 < 3'b011); end
      K_OP_IMM: begin fmt = is_shift ? FMT_SH : FMT_I; opcode = 7'b0010011; end
      K_OP:     begin fmt = FMT_R; opcode = 7'b0110011; end
      default:  kind_ok = 1'b0;
    endcase

    // The alternate funct7 only exists for SUB/SRA and SRAI.
    alt_ok = !iwAlt
           || ((iwKind == K_OP) && ((iwFunct3 == 3'b000) || (iwFunct3 == 3'b101)))
           || ((iwKind == K_OP_IMM) && (iwFunct3 == 3'b101));

    case (fmt)
      FMT_U:   enc_word = {iwImm[31:12], iwRd, opcode};
      FMT_J:   enc_word = {iwImm[20], iwImm[10:1], iwImm[11], iwImm[19:12], iwRd, opcode};
      FMT_I:   enc_word = {iwImm[11:0], iwRs1, iwFunct3, iwRd, opcode};
      FMT_SH:  enc_word = {funct7, iwImm[4:0], iwRs1, iwFunct3, iwRd, opcode};
      FMT_S:   enc_word = {iwImm[11:5], iwRs2, iwRs1, iwFunct3, iwImm[4:0], opcode};
      FMT_B:   enc_word = {iwImm[12], iwImm[10:5], iwRs2, iwRs1, iwFunct3,
                           iwImm[4:1], iwImm[11], opcode};
      default: enc_word = {funct7, iwRs2, iwRs1, iwFunct3, iwRd, opcode};
    endcase
  end

`ifdef ICE_RISC_ENC_RANGE_CHECK_EN
  // A signed value fits in N bits when every bit above N-1 equals the sign bit.
  logic fits_12;
  logic fits_13;
  logic fits_21;
  assign fits_12 = (&iwImm[31:11]) | ~(|iwImm[31:11]);
  assign fits_13 = (&iwImm[31:12]) | ~(|iwImm[31:12]);
  assign fits_21 = (&iwImm[31:20]) | ~(|iwImm[31:20]);

  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      FMT_U:        range_ok = (iwImm[11:0] == 12'h000);
      FMT_J:        range_ok = !iwImm[0] && fits_21;
      FMT_B:        range_ok = !iwImm[0] && fits_13;
      FMT_I, FMT_S: range_ok = fits_12;
      FMT_SH:       range_ok = (iwImm[31:5] == 27'h0);
      default:      range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  assign legal = kind_ok && alt_ok && range_ok;

  // ---------------- handshake, address counter, FIFO ----------------
  logic [31:0] instr_q [FIFO_DEPTH];
  logic [31:0] waddr_q [FIFO_DEPTH];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_addr;
  logic        pulse_q;
  logic [7:0]  ill_cnt_q;
  logic        accept, push, pop, drop;

  assign owInReady = (count_q < FULL_CNT);
  assign owValid   = (count_q != 2'd0);
  assign owInstr   = instr_q[rd_ptr_q];
  assign owAddr    = waddr_q[rd_ptr_q];

  assign accept = iwValid && owInReady;
  assign push   = accept && legal;
  assign drop   = accept && !legal;
  assign pop    = owValid && iwOutReady;

  // A load in the same cycle as a legal accept tags that word with iwAddr.
  assign word_addr = iwAddrLoad ? iwAddr : addr_q;
  assign addr_d    = push ? word_addr + 32'd4 : word_addr;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        waddr_q[i] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      addr_q    <= RESET_ADDR;
      pulse_q   <= 1'b0;
      ill_cnt_q <= 8'd0;
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= enc_word;
        waddr_q[wr_ptr_q] <= word_addr;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      addr_q  <= addr_d;
      pulse_q <= drop;
      if (drop && (ill_cnt_q != 8'hFF)) begin
        ill_cnt_q <= ill_cnt_q + 8'd1;
      end
    end
  end

  assign orIllegalPulse = pulse_q;
  assign orIllegalCount = ill_cnt_q;

endmodule
